id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage that sits directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake, drives rs1/rs2 to the register file, and generates the sign-extended immediate.
- Applies write-back bypass and load-use stall, then registers the decoded operands into a one-entry ID/EX output register with its own valid/ready handshake to the execute stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ENABLE_BYPASS, 1, 1 enables same-cycle write-back forwarding; 0 returns register-file data unmodified.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- if_ready  out  1  stage accepts the instruction this cycle
- rs1  out  5  register-file read address 1 = if_instr[19:15]
- rs2  out  5  register-file read address 2 = if_instr[24:20]
- read_data1  in  32  register-file combinational read data 1
- read_data2  in  32  register-file combinational read data 2
- wb_RegWrite  in  1  write-back writes the register file this cycle
- wb_rd  in  5  write-back destination
- wb_data  in  32  write-back data
- ex_load  in  1  instruction currently in EX is a load
- ex_rd  in  5  destination of the instruction in EX
- flush  in  1  squash (taken branch or jump)
- id_valid  out  1  ID/EX register holds a valid instruction
- id_ready  in  1  execute consumes the ID/EX contents
- id_pc  out  32  registered PC
- id_rs1_val  out  32  registered operand 1
- id_rs2_val  out  32  registered operand 2
- id_imm  out  32  registered sign-extended immediate
- id_rs1  out  5  registered rs1 index
- id_rs2  out  5  registered rs2 index
- id_rd  out  5  registered rd index
- id_opcode  out  7  registered opcode
- id_funct3  out  3  registered funct3
- id_funct7  out  7  registered funct7

Behaviour:
- Reset: all id_* outputs are 0, including id_valid. if_ready is 0 while reset=1. Reset overrides flush and the handshakes.
- rs1 and rs2 are combinational slices of if_instr regardless of if_valid.
- Register-use decode:
  - uses_rs1 = 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111); 1 otherwise.
  - uses_rs2 = 1 for R (0110011), S (0100011) and B (1100011); 0 otherwise.
- Operand value, per source: x0 always yields 0. Otherwise, if ENABLE_BYPASS && wb_RegWrite && wb_rd==rsN, yield wb_data. Otherwise yield read_dataN.
- Immediate by opcode:
  - I (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - All other opcodes: 0.
- hazard = ex_load && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
- if_ready = !reset && !flush && !hazard && (!id_valid || id_ready).
- Accept (if_valid && if_ready): at the next edge, all id_* fields load from decode and id_valid is set to 1. Latency is one cycle from accept to id_valid.
- No accept and id_ready=1: id_valid is cleared to 0 (bubble). Under hazard this inserts exactly one bubble per stalled cycle.
- No accept and id_ready=0: id_valid and all fields hold.
- Field registers may update only on accept; id_valid alone carries validity.
- flush=1: id_valid is cleared to 0 at the next edge and the incoming instruction is dropped. flush has priority over accept and hold.
- if_valid=0: nothing is accepted, even when if_ready=1.
- Simultaneous hazard and wb_RegWrite to the same register: the hazard stall still wins.

Test Plan:
- Reset, then present ADD x1,x2,x5 (0x005100B3) with read_data1=0x3EDCBA00 and read_data2=0xA47DEFFF, id_ready=1 → next cycle id_valid=1, id_rs1_val=0x3EDCBA00, id_rs2_val=0xA47DEFFF, id_rd=1, id_opcode=0x33.
- ADDI x3,x0,-1 (0xFFF00193) with read_data1=0xDEADBEEF → id_rs1_val=0, id_imm=0xFFFFFFFF, id_rd=3; SW x5,8(x2) (0x00512423) → id_imm=0x00000008, id_funct3=2.
- 0x005100B3 with wb_RegWrite=1, wb_rd=5, wb_data=0x12345678 and stale read_data2=0 → id_rs2_val=0x12345678. Same stimulus with wb_rd=0 → id_rs2_val=0.
- ex_load=1, ex_rd=2, if_valid=1 with 0x005100B3 for 2 cycles → if_ready=0 and id_valid=0 (bubbles) for those cycles. ex_load drops → accepted, id_valid=1 next cycle.
- id_valid=1 holding 0x005100B3 with id_ready=0 for 3 cycles → all id_* outputs unchanged and if_ready=0. Raise id_ready → new instruction accepted.
- Accept, then assert flush for one cycle with if_valid=1 → id_valid=0 next cycle and the flushed-cycle instruction never appears. Assert reset mid-stall → every id_* output is 0 next cycle.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: register-file addressing, immediate generation,
// write-back bypass, load-use stall and a one-entry ID/EX output register.
module id_stage #(
    parameter int XLEN          = 32,
    parameter bit ENABLE_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[11:7];
    assign w_funct3 = if_instr[14:12];
    assign w_funct7 = if_instr[31:25];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];

    assign w_uses_rs1 = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
    assign w_uses_rs2 = (w_opcode == OP_R || w_opcode == OP_S || w_opcode == OP_B);

    // Write-back data is not yet visible in the register file this cycle.
    always_comb begin
        w_rs1_val = read_data1;
        w_rs2_val = read_data2;
        if (rs1 == 5'd0)
            w_rs1_val = '0;
        else if (ENABLE_BYPASS && wb_RegWrite && wb_rd == rs1)
            w_rs1_val = wb_data;
        if (rs2 == 5'd0)
            w_rs2_val = '0;
        else if (ENABLE_BYPASS && wb_RegWrite && wb_rd == rs2)
            w_rs2_val = wb_data;
    end

    always_comb begin
        w_imm = '0;
        case (w_opcode)
            OP_I_ALU, OP_I_LOAD, OP_JALR:
                w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_S:
                w_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_B:
                w_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {if_instr[31:12], 12'b0};
            OP_JAL:
                w_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            default:
                w_imm = '0;
        endcase
    end

    assign w_hazard = ex_load && (ex_rd != 5'd0) &&
                      ((w_uses_rs1 && ex_rd == rs1) || (w_uses_rs2 && ex_rd == rs2));

    assign if_ready = !reset && !flush && !w_hazard && (!r_valid || id_ready);
    assign w_accept = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= if_pc;
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
            r_imm     <= w_imm;
            r_rs1     <= rs1;
            r_rs2     <= rs2;
            r_rd      <= w_rd;
            r_opcode  <= w_opcode;
            r_funct3  <= w_funct3;
            r_funct7  <= w_funct7;
        end else if (id_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign id_valid   = r_valid;
    assign id_pc      = r_pc;
    assign id_rs1_val = r_rs1_val;
    assign id_rs2_val = r_rs2_val;
    assign id_imm     = r_imm;
    assign id_rs1     = r_rs1;
    assign id_rs2     = r_rs2;
    assign id_rd      = r_rd;
    assign id_opcode  = r_opcode;
    assign id_funct3  = r_funct3;
    assign id_funct7  = r_funct7;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use stall, backpressure,
// flush and reset, with hand-computed expectations.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage #(.XLEN(32), .ENABLE_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .rs1(rs1), .rs2(rs2), .read_data1(read_data1), .read_data2(read_data2),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7(id_funct7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},  {31'b0, id_valid}, 32'h0);
        check({tag, ".pc"},     id_pc,             32'h0);
        check({tag, ".rs1val"}, id_rs1_val,        32'h0);
        check({tag, ".rs2val"}, id_rs2_val,        32'h0);
        check({tag, ".imm"},    id_imm,            32'h0);
        check({tag, ".rs1"},    {27'b0, id_rs1},   32'h0);
        check({tag, ".rs2"},    {27'b0, id_rs2},   32'h0);
        check({tag, ".rd"},     {27'b0, id_rd},    32'h0);
        check({tag, ".opc"},    {25'b0, id_opcode},32'h0);
        check({tag, ".f3"},     {29'b0, id_funct3},32'h0);
        check({tag, ".f7"},     {25'b0, id_funct7},32'h0);
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        read_data1 = '0; read_data2 = '0; wb_RegWrite = 1'b0; wb_rd = '0;
        wb_data = '0; ex_load = 1'b0; ex_rd = '0; flush = 1'b0; id_ready = 1'b1;

        tick(); tick();
        check_all_zero("reset");
        check("reset.if_ready", {31'b0, if_ready}, 32'h0);

        // ADD x1,x2,x5
        reset = 1'b0; if_valid = 1'b1; if_instr = 32'h005100B3; if_pc = 32'h100;
        read_data1 = 32'h3EDCBA00; read_data2 = 32'hA47DEFFF;
        settle();
        check("add.if_ready", {31'b0, if_ready}, 32'h1);
        check("add.rs1", {27'b0, rs1}, 32'd2);
        check("add.rs2", {27'b0, rs2}, 32'd5);
        tick();
        check("add.valid",  {31'b0, id_valid}, 32'h1);
        check("add.rs1val", id_rs1_val, 32'h3EDCBA00);
        check("add.rs2val", id_rs2_val, 32'hA47DEFFF);
        check("add.rd",     {27'b0, id_rd}, 32'd1);
        check("add.opc",    {25'b0, id_opcode}, 32'h33);
        check("add.pc",     id_pc, 32'h100);
        check("add.imm",    id_imm, 32'h0);

        // ADDI x3,x0,-1
        if_instr = 32'hFFF00193; if_pc = 32'h104; read_data1 = 32'hDEADBEEF;
        tick();
        check("addi.rs1val", id_rs1_val, 32'h0);
        check("addi.imm",    id_imm, 32'hFFFFFFFF);
        check("addi.rd",     {27'b0, id_rd}, 32'd3);

        // SW x5,8(x2)
        if_instr = 32'h00512423; if_pc = 32'h108;
        tick();
        check("sw.imm", id_imm, 32'h8);
        check("sw.f3",  {29'b0, id_funct3}, 32'd2);

        // BNE x1,x2,-8
        if_instr = 32'hFE209CE3;
        tick();
        check("bne.imm", id_imm, 32'hFFFFFFF8);
        check("bne.f7",  {25'b0, id_funct7}, 32'h7F);

        // LUI x7,0x12345: rs1 field is 8 but unused, so a load to x8 does not stall
        if_instr = 32'h123453B7; ex_load = 1'b1; ex_rd = 5'd8;
        settle();
        check("lui.if_ready", {31'b0, if_ready}, 32'h1);
        tick();
        check("lui.imm", id_imm, 32'h12345000);
        ex_load = 1'b0; ex_rd = 5'd0;

        // JAL x0,+16
        if_instr = 32'h0100006F;
        tick();
        check("jal.imm", id_imm, 32'h10);

        // write-back bypass on rs2, then wb_rd=0 must not forward
        if_instr = 32'h005100B3; read_data1 = 32'h11111111; read_data2 = 32'h0;
        wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
        tick();
        check("byp.rs2val", id_rs2_val, 32'h12345678);
        check("byp.rs1val", id_rs1_val, 32'h11111111);
        wb_rd = 5'd0;
        tick();
        check("byp0.rs2val", id_rs2_val, 32'h0);
        wb_RegWrite = 1'b0;

        // load-use on rs1 for two cycles; same-register write-back does not lift it
        ex_load = 1'b1; ex_rd = 5'd2; if_pc = 32'h200;
        wb_RegWrite = 1'b1; wb_rd = 5'd2; wb_data = 32'hCAFEF00D;
        settle();
        check("hz1.if_ready", {31'b0, if_ready}, 32'h0);
        tick();
        check("hz1.valid", {31'b0, id_valid}, 32'h0);
        check("hz2.if_ready", {31'b0, if_ready}, 32'h0);
        tick();
        check("hz2.valid", {31'b0, id_valid}, 32'h0);
        ex_load = 1'b0; wb_RegWrite = 1'b0;
        settle();
        check("hz.release", {31'b0, if_ready}, 32'h1);
        tick();
        check("hz.valid", {31'b0, id_valid}, 32'h1);
        check("hz.pc",    id_pc, 32'h200);

        // load with ex_rd=0 never stalls
        ex_load = 1'b1; ex_rd = 5'd0;
        settle();
        check("hzx0.if_ready", {31'b0, if_ready}, 32'h1);
        ex_load = 1'b0;

        // backpressure: ADD held for 3 cycles while ADDI waits
        id_ready = 1'b0; if_instr = 32'hFFF00193; if_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp.if_ready", {31'b0, if_ready}, 32'h0);
            tick();
            check("bp.valid", {31'b0, id_valid}, 32'h1);
            check("bp.pc",    id_pc, 32'h200);
            check("bp.rd",    {27'b0, id_rd}, 32'd1);
            check("bp.rs1val", id_rs1_val, 32'h11111111);
        end
        id_ready = 1'b1;
        settle();
        check("bp.release", {31'b0, if_ready}, 32'h1);
        tick();
        check("bp.new.rd", {27'b0, id_rd}, 32'd3);
        check("bp.new.pc", id_pc, 32'h300);

        // if_valid=0: bubble, nothing accepted
        if_valid = 1'b0; if_instr = 32'h005100B3; if_pc = 32'h400;
        tick();
        check("idle.valid", {31'b0, id_valid}, 32'h0);
        check("idle.pc",    id_pc, 32'h300);

        // accept, then flush with an instruction offered
        if_valid = 1'b1; if_pc = 32'h500;
        tick();
        check("fl.pre.valid", {31'b0, id_valid}, 32'h1);
        flush = 1'b1; if_instr = 32'hFFF00193; if_pc = 32'h504;
        settle();
        check("fl.if_ready", {31'b0, if_ready}, 32'h0);
        tick();
        check("fl.valid", {31'b0, id_valid}, 32'h0);
        flush = 1'b0; if_valid = 1'b0;
        tick();
        check("fl.after.valid", {31'b0, id_valid}, 32'h0);
        check("fl.after.pc",    id_pc, 32'h500);

        // reset in the middle of a backpressure stall
        if_valid = 1'b1; if_instr = 32'h005100B3; if_pc = 32'h600;
        tick();
        id_ready = 1'b0;
        tick();
        check("rs.pre.valid", {31'b0, id_valid}, 32'h1);
        reset = 1'b1; flush = 1'b1;
        settle();
        check("rs.if_ready", {31'b0, if_ready}, 32'h0);
        tick();
        check_all_zero("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
